register_file: RTL and testbench

- General-purpose register file for the FPGA CPU datapath: 8 registers x 32 bits, two combinational read ports, one synchronous write port.
- Sits between the decode/operand-fetch stage and the writeback stage.
- Exports all 8 register contents continuously as debug outputs for display/LED logic and bench observation.

---
 rtl/register_file_pkg.sv | 8 +
 rtl/register_file.sv | 54 +++++
 tb/tb_register_file.sv | 118 +++++++++++
 3 files changed

// File: rtl/register_file_pkg.sv
// Shared sizing and address type for the CPU general-purpose register file.
package register_file_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/register_file.sv
// 8x32 register file: two combinational read ports, one write port, zero-latency reads, no bypass.
// Writes land on the rising edge; reset wins over write; no flow control (always accepts).
module register_file
  import register_file_pkg::*;
(
  input  reg_addr_t          ra1,
  input  reg_addr_t          ra2,
  input  reg_addr_t          wa,
  output logic [DATA_W-1:0]  rd1,
  output logic [DATA_W-1:0]  rd2,
  input  logic [DATA_W-1:0]  wd,
  input  logic               we,
  input  logic               clk,
  input  logic               rst,
  output logic [DATA_W-1:0]  r_reg0,
  output logic [DATA_W-1:0]  r_reg1,
  output logic [DATA_W-1:0]  r_reg2,
  output logic [DATA_W-1:0]  r_reg3,
  output logic [DATA_W-1:0]  r_reg4,
  output logic [DATA_W-1:0]  r_reg5,
  output logic [DATA_W-1:0]  r_reg6,
  output logic [DATA_W-1:0]  r_reg7
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[wa] = wd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads tap storage directly, so a same-cycle write is invisible until the edge.
  assign rd1 = regs_q[ra1];
  assign rd2 = regs_q[ra2];

  assign r_reg0 = regs_q[0];
  assign r_reg1 = regs_q[1];
  assign r_reg2 = regs_q[2];
  assign r_reg3 = regs_q[3];
  assign r_reg4 = regs_q[4];
  assign r_reg5 = regs_q[5];
  assign r_reg6 = regs_q[6];
  assign r_reg7 = regs_q[7];

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed steps plus random traffic against an array model.
module tb_register_file;
  logic        clk;
  logic        rst;
  logic [2:0]  ra1, ra2, wa;
  logic [31:0] wd;
  logic        we;
  logic [31:0] rd1, rd2;
  logic [31:0] r_reg0, r_reg1, r_reg2, r_reg3, r_reg4, r_reg5, r_reg6, r_reg7;
  logic [31:0] dbg [8];

  logic [31:0] mdl [8];
  int          n_checks;
  int          n_fails;

  register_file dut (
    .ra1(ra1), .ra2(ra2), .wa(wa), .rd1(rd1), .rd2(rd2), .wd(wd), .we(we),
    .clk(clk), .rst(rst),
    .r_reg0(r_reg0), .r_reg1(r_reg1), .r_reg2(r_reg2), .r_reg3(r_reg3),
    .r_reg4(r_reg4), .r_reg5(r_reg5), .r_reg6(r_reg6), .r_reg7(r_reg7)
  );

  assign dbg[0] = r_reg0;
  assign dbg[1] = r_reg1;
  assign dbg[2] = r_reg2;
  assign dbg[3] = r_reg3;
  assign dbg[4] = r_reg4;
  assign dbg[5] = r_reg5;
  assign dbg[6] = r_reg6;
  assign dbg[7] = r_reg7;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rd1"}, rd1, mdl[ra1]);
    check({tag, ".rd2"}, rd2, mdl[ra2]);
    for (int i = 0; i < 8; i++) check($sformatf("%s.r_reg%0d", tag, i), dbg[i], mdl[i]);
  endtask

  // Drive one cycle: check outputs before the edge (pre-write view), then apply the model rules.
  task automatic step(input string tag, input logic r, input logic w, input logic [2:0] a,
                      input logic [31:0] d, input logic [2:0] p1, input logic [2:0] p2);
    @(negedge clk);
    rst = r; we = w; wa = a; wd = d; ra1 = p1; ra2 = p2;
    #1;
    check_all(tag);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 8; i++) mdl[i] = 32'h0;
    end else if (w) begin
      mdl[a] = d;
    end
  endtask

  initial begin
    logic [3:0] wide_addr;
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
    @(posedge clk);
    for (int i = 0; i < 8; i++) mdl[i] = 32'h0;

    // Reset state observed on every read address
    for (int i = 0; i < 8; i++) step("reset_rd", 1'b0, 1'b0, 3'd0, 32'h0, 3'(i), 3'(7 - i));

    step("wr3",      1'b0, 1'b1, 3'd3, 32'haaaaaaaa, 3'd3, 3'd3);
    step("rd3",      1'b0, 1'b0, 3'd0, 32'h0,        3'd3, 3'd3);
    check("basic.rd1", rd1, 32'haaaaaaaa);
    check("basic.r_reg3", r_reg3, 32'haaaaaaaa);

    // Each write also reads its own address: old value before the edge, new one next step
    step("wr4",      1'b0, 1'b1, 3'd4, 32'h55555555, 3'd4, 3'd4);
    check("no_bypass.rd1", rd1, 32'h0);
    step("wr5",      1'b0, 1'b1, 3'd5, 32'h12345678, 3'd5, 3'd4);
    step("wr6",      1'b0, 1'b1, 3'd6, 32'h87654321, 3'd6, 3'd5);
    step("wr1",      1'b0, 1'b1, 3'd1, 32'h11111111, 3'd1, 3'd6);
    step("wr2",      1'b0, 1'b1, 3'd2, 32'h22222222, 3'd2, 3'd1);
    step("wr7",      1'b0, 1'b1, 3'd7, 32'h77777777, 3'd7, 3'd2);
    step("rd7",      1'b0, 1'b0, 3'd0, 32'h0,        3'd7, 3'd7);

    step("we0_1",    1'b0, 1'b0, 3'd1, 32'h11122111, 3'd1, 3'd2);
    step("we0_2",    1'b0, 1'b0, 3'd2, 32'hbbbccbbb, 3'd1, 3'd2);
    step("we0_chk",  1'b0, 1'b0, 3'd0, 32'h0,        3'd1, 3'd2);
    check("we0.r_reg1", r_reg1, 32'h11111111);
    check("we0.r_reg2", r_reg2, 32'h22222222);

    step("wr0",      1'b0, 1'b1, 3'd0, 32'hdeadbeef, 3'd3, 3'd0);
    wide_addr = 4'd8;
    step("trunc8",   1'b0, 1'b0, 3'd0, 32'h0,        wide_addr[2:0], 3'd0);
    check("trunc8.rd1", rd1, 32'hdeadbeef);
    step("rewr0",    1'b0, 1'b1, 3'd0, 32'hdeadbeef, 3'd0, 3'd0);

    // Reset coincident with a write: reset wins
    step("rst_wr",   1'b1, 1'b1, 3'd5, 32'hffffffff, 3'd5, 3'd0);
    step("post_rst", 1'b0, 1'b0, 3'd0, 32'h0,        3'd5, 3'd7);
    check("rst.r_reg5", r_reg5, 32'h0);
    step("resume",   1'b0, 1'b1, 3'd5, 32'hcafef00d, 3'd5, 3'd5);
    step("resume_rd",1'b0, 1'b0, 3'd0, 32'h0,        3'd5, 3'd5);

    for (int n = 0; n < 300; n++) begin
      step("rand", ($urandom_range(0, 31) == 0), 1'($urandom), 3'($urandom_range(0, 7)),
           32'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    step("final", 1'b0, 1'b0, 3'd0, 32'h0, 3'd1, 3'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
